jtframe_cen_bank: RTL and testbench

- Multi-channel fractional clock-enable generator, downstream of the board PLL.
- Runs on the PLL system clock and gates all enables until PLL lock has been stable for a programmable settle time.
- Produces CH independent cen pulse trains, each with ratio num/den, so cores derive CPU, sound and video rates from one PLL output instead of adding PLL outputs.
- Generalises the fixed two-output PLL wrapper: runtime-programmable ratios, lock supervision, per-channel gating.

---
 rtl/jtframe_cen_pkg.sv | 20 ++
 rtl/jtframe_cen_ch.sv | 54 +++++
 rtl/jtframe_cen_bank.sv | 134 +++++++++++++
 tb/tb_jtframe_cen_bank.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_cen_pkg.sv
// Shared types and defaults for the fractional clock-enable bank.
package jtframe_cen_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_RUN       = 2'd2
  } cen_state_e;

  localparam int unsigned CEN_CH     = 4;
  localparam int unsigned CEN_W      = 10;
  localparam int unsigned CEN_SETTLE = 1024;
  localparam int unsigned DBG_CNT_W  = 16;

  // Select width for the debug channel mux; never narrower than one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jtframe_cen_ch.sv
// One fractional cen channel: phase accumulator producing num/den pulses per clk.
module jtframe_cen_ch
  import jtframe_cen_pkg::*;
#(
  parameter int unsigned W = CEN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic         en,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  output logic         cen
);

  logic [W-1:0] r_acc;
  logic         r_cen;
  logic [W:0]   w_sum;
  logic [W:0]   w_diff;
  logic [W-1:0] w_acc_d;
  logic         w_cen_d;

  always_comb begin
    w_sum   = {1'b0, r_acc} + {1'b0, num};
    w_diff  = w_sum - {1'b0, den};
    w_acc_d = r_acc;
    w_cen_d = 1'b0;
    if (!run || !en || den == '0) begin
      w_acc_d = '0;
    end else if (num >= den) begin
      w_acc_d = '0;
      w_cen_d = 1'b1;
    end else if (w_sum >= {1'b0, den}) begin
      w_cen_d = 1'b1;
      // A live den reduction can leave the remainder above den; restart phase.
      w_acc_d = (w_diff >= {1'b0, den}) ? '0 : w_diff[W-1:0];
    end else begin
      w_acc_d = w_sum[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cen <= 1'b0;
    end else begin
      r_acc <= w_acc_d;
      r_cen <= w_cen_d;
    end
  end

  assign cen = r_cen;

endmodule

// File: rtl/jtframe_cen_bank.sv
// Multi-channel fractional cen generator gated by supervised PLL lock.
// Optional JTFRAME_CEN_CNT_EN adds a per-channel pulse counter for debug.
module jtframe_cen_bank
  import jtframe_cen_pkg::*;
#(
  parameter int unsigned CH     = CEN_CH,
  parameter int unsigned W      = CEN_W,
  parameter int unsigned SETTLE = CEN_SETTLE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pll_locked,
  input  logic [CH-1:0]              ch_en,
  input  logic [CH*W-1:0]            num,
  input  logic [CH*W-1:0]            den,
`ifdef JTFRAME_CEN_CNT_EN
  input  logic [sel_w(CH)-1:0]       dbg_sel,
  output logic [DBG_CNT_W-1:0]       dbg_cnt,
`endif
  output logic [CH-1:0]              cen,
  output logic                       ready
);

  localparam int unsigned CW = $clog2(SETTLE + 1);
  // RUN is entered on the edge where the counter reaches SETTLE-1.
  localparam logic [CW-1:0] CNT_LAST = CW'((SETTLE > 1) ? SETTLE - 2 : 0);

  logic          r_lk_meta;
  logic          r_lk_s;
  cen_state_e    r_state;
  cen_state_e    w_state_d;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_d;
  logic          r_ready;
  logic          w_run;
  logic [CH-1:0] w_cen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lk_meta <= 1'b0;
      r_lk_s    <= 1'b0;
    end else begin
      r_lk_meta <= pll_locked;
      r_lk_s    <= r_lk_meta;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      ST_WAIT_LOCK: begin
        w_cnt_d = '0;
        if (r_lk_s) w_state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!r_lk_s) begin
          w_state_d = ST_WAIT_LOCK;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
          if (r_cnt >= CNT_LAST) w_state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!r_lk_s) begin
          w_state_d = ST_WAIT_LOCK;
          w_cnt_d   = '0;
        end
      end
      default: begin
        w_state_d = ST_WAIT_LOCK;
        w_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_WAIT_LOCK;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_ready <= (w_state_d == ST_RUN);
    end
  end

  // Channels clear on the same edge that leaves RUN, so cen drops with ready.
  assign w_run = (r_state == ST_RUN) && r_lk_s;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    jtframe_cen_ch #(
      .W (W)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (w_run),
      .en    (ch_en[g]),
      .num   (num[g*W +: W]),
      .den   (den[g*W +: W]),
      .cen   (w_cen[g])
    );
  end

  assign cen   = w_cen;
  assign ready = r_ready;

`ifdef JTFRAME_CEN_CNT_EN
  logic [sel_w(CH)-1:0] r_dbg_sel;
  logic [DBG_CNT_W-1:0] r_dbg_cnt;
  logic                 w_dbg_hit;

  assign w_dbg_hit = (32'(dbg_sel) < CH) && w_cen[dbg_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dbg_sel <= '0;
      r_dbg_cnt <= '0;
    end else begin
      r_dbg_sel <= dbg_sel;
      if (!w_run || dbg_sel != r_dbg_sel) begin
        r_dbg_cnt <= '0;
      end else if (w_dbg_hit) begin
        r_dbg_cnt <= r_dbg_cnt + 1'b1;
      end
    end
  end

  assign dbg_cnt = r_dbg_cnt;
`endif

endmodule

// File: tb/tb_jtframe_cen_bank.sv
// Directed bench for jtframe_cen_bank with SETTLE=16; debug counter checked if JTFRAME_CEN_CNT_EN.
module tb_jtframe_cen_bank;

  localparam int CH = 4;
  localparam int W  = 10;

  logic          clk;
  logic          rst_n;
  logic          pll_locked;
  logic [CH-1:0] ch_en;
  logic [CH*W-1:0] num;
  logic [CH*W-1:0] den;
  logic [CH-1:0] cen;
  logic          ready;
`ifdef JTFRAME_CEN_CNT_EN
  logic [1:0]    dbg_sel;
  logic [15:0]   dbg_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  jtframe_cen_bank #(
    .CH     (CH),
    .W      (W),
    .SETTLE (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .ch_en      (ch_en),
    .num        (num),
    .den        (den),
`ifdef JTFRAME_CEN_CNT_EN
    .dbg_sel    (dbg_sel),
    .dbg_cnt    (dbg_cnt),
`endif
    .cen        (cen),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int i, input int n, input int d);
    num[i*W +: W] = W'(n);
    den[i*W +: W] = W'(d);
  endtask

  initial begin
    int quiet;
    int p0;
    logic [3:0] e;

    clk        = 1'b0;
    rst_n      = 1'b0;
    pll_locked = 1'b1;
    ch_en      = 4'hF;
    num        = '0;
    den        = '0;
`ifdef JTFRAME_CEN_CNT_EN
    dbg_sel    = 2'd0;
`endif
    set_ch(0, 1, 4);
    set_ch(1, 3, 8);
    set_ch(2, 5, 4);
    set_ch(3, 3, 0);

    repeat (3) tick();
    check("reset_ready", 32'(ready), 0);
    check("reset_cen", 32'(cen), 0);
`ifdef JTFRAME_CEN_CNT_EN
    check("reset_dbg_cnt", 32'(dbg_cnt), 0);
`endif

    // Startup: ready rises exactly 18 edges after release.
    rst_n = 1'b1;
    quiet = 0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (cen != 4'h0) quiet++;
    end
    check("startup_ready_low_17", 32'(ready), 0);
    check("startup_cen_quiet", 32'(quiet), 0);
    tick();
    check("startup_ready_18", 32'(ready), 1);

    // RUN cycle 0 from here; ch0 1/4, ch1 3/8, ch2 5/4, ch3 den=0.
    p0 = 0;
    for (int n = 0; n <= 100; n++) begin
      e[0] = (n > 0) && (n % 4 == 0);
      e[1] = (n > 0) && ((n % 8 == 3) || (n % 8 == 6) || (n % 8 == 0));
      e[2] = (n >= 1);
      e[3] = 1'b0;
      check($sformatf("run_cen_n%0d", n), 32'(cen), 32'(e));
      if (n >= 1 && cen[0]) p0++;
      tick();
    end
    check("ch0_pulses_100", 32'(p0), 25);
`ifdef JTFRAME_CEN_CNT_EN
    check("dbg_cnt_100", 32'(dbg_cnt), 25);
`endif

    // Gate ch2 for 10 cycles, reprogram to 1/3; phase restarts on re-enable.
    ch_en[2] = 1'b0;
    set_ch(2, 1, 3);
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cen[2]) quiet++;
    end
    check("gate_ch2_quiet", 32'(quiet), 0);
    ch_en[2] = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      tick();
      check($sformatf("regate_ch2_j%0d", j), 32'(cen[2]), 32'(j % 3 == 0));
    end

    // num=0 never pulses.
    set_ch(3, 0, 4);
    quiet = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cen[3]) quiet++;
    end
    check("num0_quiet", 32'(quiet), 0);

    // Live den drop below acc: 1/8 until acc=6, then den=2 clamps acc to 0.
    set_ch(3, 1, 8);
    quiet = 0;
    for (int j = 1; j <= 6; j++) begin
      tick();
      if (cen[3]) quiet++;
    end
    check("live_pre_quiet", 32'(quiet), 0);
    set_ch(3, 1, 2);
    tick();
    check("live_pulse_a", 32'(cen[3]), 1);
    tick();
    check("live_no_double", 32'(cen[3]), 0);
    tick();
    check("live_pulse_b", 32'(cen[3]), 1);

    // Lock loss: ready/cen drop on the third edge.
    pll_locked = 1'b0;
    tick();
    tick();
    check("lockloss_ready_hold", 32'(ready), 1);
    tick();
    check("lockloss_ready_drop", 32'(ready), 0);
    check("lockloss_cen_drop", 32'(cen), 0);
    quiet = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ready || cen != 4'h0) quiet++;
    end
    check("lockloss_hold_quiet", 32'(quiet), 0);

    pll_locked = 1'b1;
    quiet = 0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (cen != 4'h0) quiet++;
    end
    check("relock_ready_low_17", 32'(ready), 0);
    check("relock_cen_quiet", 32'(quiet), 0);
    tick();
    check("relock_ready_18", 32'(ready), 1);
    for (int j = 1; j <= 8; j++) begin
      tick();
      check($sformatf("relock_ch0_j%0d", j), 32'(cen[0]), 32'(j % 4 == 0));
    end
`ifdef JTFRAME_CEN_CNT_EN
    check("dbg_cnt_relock", 32'(dbg_cnt), 1);
`endif

    // Asynchronous reset mid-RUN.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_ready", 32'(ready), 0);
    check("async_reset_cen", 32'(cen), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
